// File: rtl/nmi_bus_arbiter_if.sv
// nmi_if: native memory interface bundle (request valid/addr/wdata/wstrb, response ready/rdata).
// wstrb == 0 marks a read; ready is a single-cycle pulse that completes the access.
interface nmi_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, addr, wdata, wstrb, input ready, rdata);
    modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/nmi_bus_arbiter.sv
// nmi_bus_arbiter: round-robin 2:1 arbiter merging the CPU and DMA NMI masters onto one NMI port.
// Define NMI_ARB_TIMEOUT_EN to add the watchdog that aborts accesses stuck in BUSY.
module nmi_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic  clk_i,
    input  logic  rst_n_i,
    nmi_if.slave  cpu_nmi,
    nmi_if.slave  dma_nmi,
    nmi_if.master nmi,
    output logic  gnt_dma_o,
    output logic  timeout_o
);
    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

    state_e      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        up_ready;
    logic [31:0] up_rdata;
    logic        abort;

    // The watchdog counter is 16 bits and saturates, so expiry must fit below its ceiling.
    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536) begin : g_bad_timeout
        $error("nmi_bus_arbiter: TIMEOUT_CYC must lie in 2..65536");
    end

    always_comb begin
        if (gnt_q) begin
            m_valid = dma_nmi.valid;
            m_addr  = dma_nmi.addr;
            m_wdata = dma_nmi.wdata;
            m_wstrb = dma_nmi.wstrb;
        end else begin
            m_valid = cpu_nmi.valid;
            m_addr  = cpu_nmi.addr;
            m_wdata = cpu_nmi.wdata;
            m_wstrb = cpu_nmi.wstrb;
        end
    end

`ifdef NMI_ARB_TIMEOUT_EN
    localparam logic [15:0] EXPIRE = 16'(TIMEOUT_CYC - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        tmo_q, tmo_d;

    // A ready arriving in the expiry cycle wins, hence the !nmi.ready term.
    assign abort = (state_q == ST_BUSY) && m_valid && !nmi.ready && (cnt_q == EXPIRE);

    always_comb begin
        cnt_d = cnt_q;
        tmo_d = tmo_q | abort;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (!nmi.ready && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout_o = tmo_q;
`else
    assign abort     = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        last_d        = last_q;
        up_ready      = 1'b0;
        up_rdata      = '0;
        nmi.valid     = 1'b0;
        nmi.addr      = '0;
        nmi.wdata     = '0;
        nmi.wstrb     = '0;
        cpu_nmi.ready = 1'b0;
        cpu_nmi.rdata = '0;
        dma_nmi.ready = 1'b0;
        dma_nmi.rdata = '0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_nmi.valid && dma_nmi.valid) begin
                    gnt_d   = ~last_q;
                    state_d = ST_BUSY;
                end else if (cpu_nmi.valid) begin
                    gnt_d   = 1'b0;
                    state_d = ST_BUSY;
                end else if (dma_nmi.valid) begin
                    gnt_d   = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                nmi.valid = m_valid & ~abort;
                nmi.addr  = m_addr;
                nmi.wdata = m_wdata;
                nmi.wstrb = m_wstrb;
                // A master abandoning its request ends the grant without touching fairness.
                if (!m_valid) begin
                    state_d = ST_IDLE;
                end else if (nmi.ready) begin
                    up_ready = 1'b1;
                    up_rdata = nmi.rdata;
                    last_d   = gnt_q;
                    state_d  = ST_IDLE;
                end else if (abort) begin
                    up_ready = 1'b1;
                    up_rdata = ERR_RDATA;
                    last_d   = gnt_q;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (gnt_q) begin
            dma_nmi.ready = up_ready;
            dma_nmi.rdata = up_rdata;
        end else begin
            cpu_nmi.ready = up_ready;
            cpu_nmi.rdata = up_rdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    assign gnt_dma_o = (state_q == ST_BUSY) && gnt_q;
endmodule
